// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default parameters,
// state encodings and the sequential-PC helper.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_KILL  = 2'd3
  } if_state_e;

  // Next sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc,
                                         input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters, only compiled when IF_PERF_CNT_EN is
// defined: number of delivered instructions and number of discarded
// Icache responses. Both wrap at 2^32.
`ifdef IF_PERF_CNT_EN
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic        cache_ready,
  output logic [31:0] fetch_cnt,
  output logic [31:0] kill_cnt
);

  // Count accepted instructions and responses that were thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (inst_valid)                fetch_cnt <= fetch_cnt + 32'd1;
      if (cache_ready && !inst_valid) kill_cnt  <= kill_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC and the Icache request
// handshake, applies redirects and stalls from flow control, and qualifies
// each returned instruction for decode.
// Optional macro IF_PERF_CNT_EN adds fetch/kill performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fc_stall_if_i,
  input  logic        fc_jump_flag_i,
  input  logic [31:0] fc_jump_pc_i,
  input  logic        Icache_ready_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  output logic [31:0] if_pc_o,
  output logic        if_inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_fetch_cnt_o,
  output logic [31:0] if_kill_cnt_o
`endif
);

  if_state_e   state, state_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] redirect_pc, redirect_pc_nxt;
  if_state_e   resume_state;

  // After a response (or from an idle state) go fetch unless stalled.
  assign resume_state = fc_stall_if_i ? IF_HOLD : IF_FETCH;

  // State, fetch PC and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_BOOT;
      fetch_addr  <= RESET_PC;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      fetch_addr  <= fetch_addr_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // Next-state logic; redirect outranks stall, which outranks advance.
  always_comb begin
    state_nxt       = state;
    fetch_addr_nxt  = fetch_addr;
    redirect_pc_nxt = redirect_pc;
    case (state)
      IF_BOOT, IF_HOLD: begin
        // No request outstanding, so a redirect lands in the PC directly.
        if (fc_jump_flag_i) fetch_addr_nxt = fc_jump_pc_i;
        state_nxt = resume_state;
      end
      IF_FETCH: begin
        if (Icache_ready_i) begin
          fetch_addr_nxt = fc_jump_flag_i ? fc_jump_pc_i
                                          : seq_pc(fetch_addr, PC_STEP);
          state_nxt      = resume_state;
        end else if (fc_jump_flag_i) begin
          // Request cannot be withdrawn; park the target until it returns.
          redirect_pc_nxt = fc_jump_pc_i;
          state_nxt       = IF_KILL;
        end
      end
      IF_KILL: begin
        if (fc_jump_flag_i) redirect_pc_nxt = fc_jump_pc_i;
        if (Icache_ready_i) begin
          fetch_addr_nxt = fc_jump_flag_i ? fc_jump_pc_i : redirect_pc;
          state_nxt      = resume_state;
        end
      end
      default: state_nxt = IF_BOOT;
    endcase
  end

  assign if_req_o        = (state == IF_FETCH) || (state == IF_KILL);
  assign if_addr_o       = fetch_addr;
  assign if_pc_o         = fetch_addr;
  assign if_inst_valid_o = Icache_ready_i && (state == IF_FETCH) && !fc_jump_flag_i;

`ifdef IF_PERF_CNT_EN
  if_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_valid  (if_inst_valid_o),
    .cache_ready (Icache_ready_i),
    .fetch_cnt   (if_fetch_cnt_o),
    .kill_cnt    (if_kill_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: per-cycle vector table plus a
// reset-during-KILL sequence.
`timescale 1ns/1ps
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fc_stall_if_i;
  logic        fc_jump_flag_i;
  logic [31:0] fc_jump_pc_i;
  logic        Icache_ready_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic [31:0] if_pc_o;
  logic        if_inst_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_fetch_cnt_o;
  logic [31:0] if_kill_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fc_stall_if_i   (fc_stall_if_i),
    .fc_jump_flag_i  (fc_jump_flag_i),
    .fc_jump_pc_i    (fc_jump_pc_i),
    .Icache_ready_i  (Icache_ready_i),
    .if_req_o        (if_req_o),
    .if_addr_o       (if_addr_o),
    .if_pc_o         (if_pc_o),
    .if_inst_valid_o (if_inst_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .if_fetch_cnt_o  (if_fetch_cnt_o),
    .if_kill_cnt_o   (if_kill_cnt_o)
`endif
  );

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jpc;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
  } vec_t;

  vec_t vecs[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid);
    check({tag, " req"},   {31'd0, if_req_o},        {31'd0, req});
    check({tag, " addr"},  if_addr_o,                addr);
    check({tag, " valid"}, {31'd0, if_inst_valid_o}, {31'd0, valid});
    if (valid) check({tag, " pc"}, if_pc_o, addr);
  endtask

  initial begin
    //           stall jump jpc           ready req addr          valid
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0}; // BOOT
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 32'h8,        1'b0}; // same-cycle redirect
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104,      1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h200,      1'b0, 1'b1, 32'h104,      1'b0}; // -> KILL
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104,      1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b0}; // killed response
    vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0}; // stall, pending
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      1'b1};
    vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h204,      1'b0}; // HOLD
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h204,      1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h204,      1'b0};
    vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      1'b1};
    vecs[19] = '{1'b1, 1'b1, 32'h300,      1'b0, 1'b0, 32'h208,      1'b0}; // redirect in HOLD
    vecs[20] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h300,      1'b0}; // stray ready in HOLD
    vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h300,      1'b0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b0};
    vecs[23] = '{1'b0, 1'b1, 32'h400,      1'b0, 1'b1, 32'h300,      1'b0}; // -> KILL
    vecs[24] = '{1'b0, 1'b1, 32'h500,      1'b0, 1'b1, 32'h300,      1'b0}; // latest wins
    vecs[25] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      1'b0};
    vecs[26] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h500,      1'b1};
    vecs[27] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h504,     1'b0};
    vecs[28] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1};
    vecs[29] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0}; // wrapped

    rst_n          = 1'b0;
    fc_stall_if_i  = 1'b0;
    fc_jump_flag_i = 1'b0;
    fc_jump_pc_i   = 32'h0;
    Icache_ready_i = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst req",   {31'd0, if_req_o},        32'd0);
    check("rst valid", {31'd0, if_inst_valid_o}, 32'd0);
    check("rst pc",    if_pc_o,                  32'h0);
    check("rst addr",  if_addr_o,                32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      fc_stall_if_i  = vecs[i].stall;
      fc_jump_flag_i = vecs[i].jump;
      fc_jump_pc_i   = vecs[i].jpc;
      Icache_ready_i = vecs[i].ready;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid);
    end

`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", if_fetch_cnt_o, 32'd7);
    check("kill_cnt",  if_kill_cnt_o,  32'd5);
`endif

    // Reset arriving while in KILL.
    @(negedge clk);
    fc_jump_flag_i = 1'b1;
    fc_jump_pc_i   = 32'h600;
    Icache_ready_i = 1'b0;
    #1 check_outs("kill_enter", 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    fc_jump_flag_i = 1'b0;
    fc_jump_pc_i   = 32'h0;
    #1 check_outs("kill_wait", 1'b1, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    Icache_ready_i = 1'b1;
    #1;
    check("rstkill req",   {31'd0, if_req_o},        32'd0);
    check("rstkill valid", {31'd0, if_inst_valid_o}, 32'd0);
    check("rstkill pc",    if_pc_o,                  32'h0);
`ifdef IF_PERF_CNT_EN
    check("rstkill fetch_cnt", if_fetch_cnt_o, 32'd0);
    check("rstkill kill_cnt",  if_kill_cnt_o,  32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    Icache_ready_i = 1'b0;
    @(negedge clk);
    #1 check_outs("reboot", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    Icache_ready_i = 1'b1;
    #1 check_outs("refetch", 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    Icache_ready_i = 1'b0;
    #1 check_outs("refetch_next", 1'b1, 32'h4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the fetch PC and the request handshake to the Icache. The Icache's instruction data and ready pulse go straight to decode.
- Applies redirects from the flow-control unit (jal/jalr/taken branch) and stalls from the flow-control unit.
- Drives the fetch PC toward if_id_reg and a valid qualifier for each returned instruction.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release.
- PC_STEP, 4, PC increment per sequential fetch (no compressed instructions).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- fc_stall_if_i  in  1  hold the PC; issue no new request
- fc_jump_flag_i  in  1  single-cycle redirect pulse
- fc_jump_pc_i  in  32  redirect target
- Icache_ready_i  in  1  one-cycle pulse: response for if_addr_o is valid this cycle
- if_req_o  out  1  fetch request, level
- if_addr_o  out  32  fetch address; stable while if_req_o is high and not yet acknowledged
- if_pc_o  out  32  PC of the instruction returned this cycle, to if_id_reg
- if_inst_valid_o  out  1  returned instruction is on the correct path and must be accepted by decode

Behaviour:
- Reset, asynchronous:
  - state = BOOT; fetch_addr = RESET_PC; redirect_pc = 0.
  - if_req_o = 0; if_inst_valid_o = 0; if_pc_o = RESET_PC.
- States: BOOT, FETCH, HOLD, KILL, 2-bit encoding.
- BOOT: lasts one cycle, then goes to FETCH (or HOLD if stalled). if_req_o = 0.
- FETCH: if_req_o = 1; if_addr_o = fetch_addr.
  - On Icache_ready_i with no redirect:
    - if_inst_valid_o = 1; if_pc_o = fetch_addr.
    - Next cycle fetch_addr = fetch_addr + PC_STEP, 32-bit wrap.
    - Next state = HOLD if fc_stall_if_i, else FETCH.
- HOLD: if_req_o = 0; fetch_addr held.
  - Leaves to FETCH in the first cycle fc_stall_if_i = 0.
  - A redirect in HOLD loads fetch_addr = fc_jump_pc_i and stays in HOLD while stalled.
- Redirect in FETCH, same cycle as Icache_ready_i:
  - if_inst_valid_o = 0.
  - Next cycle fetch_addr = fc_jump_pc_i, state FETCH (HOLD if stalled).
- Redirect in FETCH, no ready yet: the request cannot be withdrawn.
  - redirect_pc = fc_jump_pc_i; next state KILL.
- KILL: if_req_o = 1 at the old address.
  - On ready: if_inst_valid_o = 0; fetch_addr = redirect_pc; then go to FETCH (HOLD if stalled).
  - A second redirect while in KILL overwrites redirect_pc; the latest one wins.
- Stall while a request is outstanding: the request completes normally and decode buffers it. The stall only blocks the next request.
- Priority each cycle: reset > redirect > stall > sequential advance.
- if_inst_valid_o = Icache_ready_i & state == FETCH & !fc_jump_flag_i. It is combinational, with zero added latency.
- Icache_ready_i in BOOT or HOLD is a protocol error: ignored, if_inst_valid_o = 0.
- Throughput: one instruction per two cycles (ready, then re-request). No back-to-back request on the ready cycle.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs if_fetch_cnt_o[31:0] (counts if_inst_valid_o cycles) and if_kill_cnt_o[31:0] (counts ready cycles with if_inst_valid_o = 0).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- define.v gains:
  - RESET_PC default.
  - IF state encodings: IF_BOOT = 2'd0, IF_FETCH = 2'd1, IF_HOLD = 2'd2, IF_KILL = 2'd3.
  - PC_STEP.
- One sub-module: if_perf_cnt, holding the two counters. It is instantiated only under IF_PERF_CNT_EN.

Test Plan:
- Sequential fetch: release reset, ready returns 2 cycles after each request → addresses 0x0, 0x4, 0x8 in order; if_inst_valid_o high once per ready; if_pc_o matches each address.
- Same-cycle redirect: jump to 0x100 on the ready for 0x8 → valid = 0 that cycle; next request address is 0x100.
- Redirect before ready: jump to 0x200 one cycle after the request for 0xC, ready two cycles later → state passes through KILL; valid = 0 on that ready; next request address is 0x200.
- Stall during outstanding request: stall rises while 0x10 is pending, ready arrives, stall held 3 cycles → valid = 1 for 0x10; if_req_o = 0 for 3 cycles; then a request for 0x14.
- Redirect in HOLD under stall: redirect to 0x300 while stalled → no request until stall drops; first request is 0x300.
- Reset mid-KILL: assert rst_n = 0 in KILL → if_req_o = 0 immediately; restart at RESET_PC. With IF_PERF_CNT_EN defined, both counters read 0.
